id_lmsm_sequencer: RTL
======================

Name: id_lmsm_sequencer

Overview:
Decode-stage producer that feeds the ID/EX pipeline register. It sits between the IF/ID register and the ID/EX register.
- Ordinary instructions pass through one per cycle.
- LM/SM (load/store multiple) instructions expand into one micro-op per set bit of the 8-bit register mask, one per cycle.
- While a sequence is in progress, it stalls IF/ID and drives the ID/EX inputs and enable.

Parameters:
OPC_LM, 4'b0110, opcode (Instr[15:12]) of load-multiple
OPC_SM, 4'b0111, opcode of store-multiple
WR_EN_BIT, 7, index in Control of the register-file write enable
MEM_WR_BIT, 0, index in Control of the memory write enable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
Valid_In  in  1  IF/ID holds a valid instruction
PC_In  in  16  PC of the incoming instruction
Instr_In  in  16  incoming instruction word
Control_In  in  10  decoded control word for the incoming instruction
Down_Stall  in  1  ID/EX not accepting (hazard unit stall)
Flush  in  1  kill the instruction in decode (taken branch in EX)
Uop_Valid_Out  out  1  micro-op valid; drives ID/EX enable
PC_Out  out  16  PC of the parent instruction
Instr_Out  out  16  parent instruction word
Control_Out  out  10  control word for this micro-op
RF_A1_Out  out  3  base/source register A1
RF_A2_Out  out  3  register A2
Reg_Idx_Out  out  3  LM destination / SM source register
Offset_Out  out  3  word offset from the base address
First_Uop_Out  out  1  first micro-op of the instruction
Last_Uop_Out  out  1  last micro-op of the instruction
Upstream_Stall_Out  out  1  hold IF/ID
Seq_Stall_Cnt_Out  out  16  sequencing stall count (optional feature)

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clk):
  - state=IDLE, mask register=0, offset counter=0.
  - All registered outputs 0.
- Outputs are registered: 1-cycle latency from acceptance to Uop_Valid_Out.
- Upstream_Stall_Out = Down_Stall | (state==SEQ), combinational.
- Priority per clock edge: reset > Flush > Down_Stall > normal operation.
- Flush:
  - Next cycle: Uop_Valid_Out=0, state=IDLE, mask=0.
  - All other outputs hold their values.
- Down_Stall=1 without Flush: state, mask, counter and all outputs hold.
- IDLE, Valid_In=0: Uop_Valid_Out<=0.
- IDLE, Valid_In=1, opcode is neither LM nor SM:
  - Uop_Valid_Out<=1; PC, Instr and Control pass through.
  - RF_A1_Out<=Instr_In[11:9], RF_A2_Out<=Instr_In[8:6].
  - First=Last=1, Offset=0, Reg_Idx=0.
- IDLE, LM/SM, mask=Instr_In[7:0]:
  - Bit i selects register Ri; micro-ops issue lowest index first.
  - Offset counts the micro-ops already emitted for this instruction (0,1,2,...).
  - Every micro-op: RF_A1_Out=Instr[11:9] (base), RF_A2_Out=Reg_Idx_Out.
  - Mask ≠ 0: emit the micro-op for the lowest set bit with First=1 and Offset=0. Remaining mask = mask with the lowest set bit cleared.
    - Remaining ≠ 0: Last=0, go to SEQ.
    - Remaining = 0: Last=1, stay in IDLE.
  - Mask = 0: emit one micro-op with First=Last=1 and Control bits WR_EN_BIT and MEM_WR_BIT forced to 0.
- SEQ:
  - Each non-stalled cycle, emit the lowest remaining bit with First=0 and the offset counter incremented.
  - Instruction inputs are ignored; the latched copy is used.
  - When the remaining mask becomes 0: Last=1, next state IDLE.
  - IF/ID holds the next instruction during SEQ; IDLE accepts it the cycle after Last. No bubble is inserted.
- Offset never wraps: at most 8 micro-ops per instruction, offset ≤ 7.

Optional Feature:
LMSM_STALL_CNT_EN.
- Defined: Seq_Stall_Cnt_Out is a 16-bit counter.
  - Increments on each clk edge with state==SEQ and Down_Stall=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: Seq_Stall_Cnt_Out is tied to 0; no counter logic.

Test Plan:
1. ADD passthrough, Instr_In=16'h1050, Valid_In=1 → next cycle:
   - Uop_Valid=1, Instr_Out=16'h1050, RF_A1=0, RF_A2=1.
   - First=Last=1, Upstream_Stall=0.
2. LM with base R2, mask 8'h29 (Instr=16'h6429) → 3 consecutive micro-ops:
   - Reg_Idx 0,3,5; Offset 0,1,2; RF_A1=2.
   - Last only on the third micro-op.
   - Upstream_Stall=1 for exactly 2 cycles.
3. SM with mask 8'h81, Down_Stall=1 for 2 cycles after the first micro-op → outputs hold (Reg_Idx=0, Offset=0). Then one micro-op with Reg_Idx=7, Offset=1, Last=1.
4. LM with mask 8'hFF, Flush during the third micro-op → next cycle Uop_Valid=0, state IDLE. The following ADD is accepted normally.
5. LM with mask 8'h00, Control_In=10'h3FF → single micro-op, Control_Out=10'h37E, First=Last=1.
6. rst=0 asserted asynchronously mid-sequence (mask 8'hF0) → all outputs 0 before the next clk edge. After release, IDLE accepts a new instruction; counter=0 when LMSM_STALL_CNT_EN is defined.

Source files
------------

// File: rtl/id_lmsm_sequencer.sv
// Decode-stage producer for ID/EX: passes ordinary instructions and expands LM/SM into one micro-op per mask bit.
// Latency 1 cycle (registered outputs); Down_Stall holds all state and outputs, Upstream_Stall_Out holds IF/ID.
// Optional macro LMSM_STALL_CNT_EN enables the saturating SEQ-cycle counter on Seq_Stall_Cnt_Out.
module id_lmsm_sequencer #(
    parameter logic [3:0] OPC_LM     = 4'b0110,
    parameter logic [3:0] OPC_SM     = 4'b0111,
    parameter int         WR_EN_BIT  = 7,
    parameter int         MEM_WR_BIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_In,
    input  logic [15:0] PC_In,
    input  logic [15:0] Instr_In,
    input  logic [9:0]  Control_In,
    input  logic        Down_Stall,
    input  logic        Flush,
    output logic        Uop_Valid_Out,
    output logic [15:0] PC_Out,
    output logic [15:0] Instr_Out,
    output logic [9:0]  Control_Out,
    output logic [2:0]  RF_A1_Out,
    output logic [2:0]  RF_A2_Out,
    output logic [2:0]  Reg_Idx_Out,
    output logic [2:0]  Offset_Out,
    output logic        First_Uop_Out,
    output logic        Last_Uop_Out,
    output logic        Upstream_Stall_Out,
    output logic [15:0] Seq_Stall_Cnt_Out
);

    typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

    state_t     state;
    logic [7:0] mask;
    logic [7:0] in_mask;
    logic [7:0] in_rest;
    logic [7:0] seq_rest;
    logic       is_lmsm;
    logic [9:0] ctrl_forced;

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign in_mask  = Instr_In[7:0];
    assign in_rest  = in_mask & (in_mask - 8'd1);
    assign seq_rest = mask & (mask - 8'd1);
    assign is_lmsm  = (Instr_In[15:12] == OPC_LM) || (Instr_In[15:12] == OPC_SM);

    // An empty-mask LM/SM still issues one micro-op, but it must not write anything.
    always_comb begin
        ctrl_forced             = Control_In;
        ctrl_forced[WR_EN_BIT]  = 1'b0;
        ctrl_forced[MEM_WR_BIT] = 1'b0;
    end

    assign Upstream_Stall_Out = Down_Stall | (state == SEQ);

    // During SEQ the parent PC/Instr/Control/base stay in the output registers, so they double as the latched copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mask          <= 8'd0;
            Uop_Valid_Out <= 1'b0;
            PC_Out        <= 16'd0;
            Instr_Out     <= 16'd0;
            Control_Out   <= 10'd0;
            RF_A1_Out     <= 3'd0;
            RF_A2_Out     <= 3'd0;
            Reg_Idx_Out   <= 3'd0;
            Offset_Out    <= 3'd0;
            First_Uop_Out <= 1'b0;
            Last_Uop_Out  <= 1'b0;
        end else if (Flush) begin
            Uop_Valid_Out <= 1'b0;
            state         <= IDLE;
            mask          <= 8'd0;
        end else if (!Down_Stall) begin
            if (state == SEQ) begin
                Uop_Valid_Out <= 1'b1;
                Reg_Idx_Out   <= low_idx(mask);
                RF_A2_Out     <= low_idx(mask);
                Offset_Out    <= Offset_Out + 3'd1;
                First_Uop_Out <= 1'b0;
                Last_Uop_Out  <= (seq_rest == 8'd0);
                mask          <= seq_rest;
                if (seq_rest == 8'd0) state <= IDLE;
            end else if (Valid_In) begin
                Uop_Valid_Out <= 1'b1;
                PC_Out        <= PC_In;
                Instr_Out     <= Instr_In;
                RF_A1_Out     <= Instr_In[11:9];
                Offset_Out    <= 3'd0;
                First_Uop_Out <= 1'b1;
                if (is_lmsm) begin
                    Reg_Idx_Out <= low_idx(in_mask);
                    RF_A2_Out   <= low_idx(in_mask);
                    if (in_mask == 8'd0) begin
                        Control_Out  <= ctrl_forced;
                        Last_Uop_Out <= 1'b1;
                        mask         <= 8'd0;
                    end else begin
                        Control_Out  <= Control_In;
                        Last_Uop_Out <= (in_rest == 8'd0);
                        mask         <= in_rest;
                        state        <= (in_rest != 8'd0) ? SEQ : IDLE;
                    end
                end else begin
                    Control_Out  <= Control_In;
                    RF_A2_Out    <= Instr_In[8:6];
                    Reg_Idx_Out  <= 3'd0;
                    Last_Uop_Out <= 1'b1;
                    mask         <= 8'd0;
                end
            end else begin
                Uop_Valid_Out <= 1'b0;
            end
        end
    end

`ifdef LMSM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Seq_Stall_Cnt_Out <= 16'd0;
        end else if ((state == SEQ) && !Down_Stall && (Seq_Stall_Cnt_Out != 16'hFFFF)) begin
            Seq_Stall_Cnt_Out <= Seq_Stall_Cnt_Out + 16'd1;
        end
    end
`else
    assign Seq_Stall_Cnt_Out = 16'd0;
`endif

endmodule
